// File: rtl/reg_release.sv
// Holding buffer between commit-time register releases and the free-list queue.
// Optional same-cycle bypass of the first released tag when `RELEASE_BYPASS_EN is defined.
module reg_release #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rel0_valid,
   input  logic [WIDTH-1:0]           rel0_tag,
   input  logic                       rel1_valid,
   input  logic [WIDTH-1:0]           rel1_tag,
   output logic                       rel_stall,
   output logic                       enque,
   output logic [WIDTH-1:0]           enque_data,
   input  logic                       halt,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 2);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head, tail;
   logic [CW-1:0]    count;
   logic             acc0, acc1, wr0, wr1, pop_mem;

   // Committed releases are architectural, so a flush has nothing to undo here.
   logic flush_unused;
   assign flush_unused = flush;

   assign pending   = count;
   assign rel_stall = count > STALL_LVL;
   assign acc0      = ~rel_stall & rel0_valid & (rel0_tag != '0);
   assign acc1      = ~rel_stall & rel1_valid & (rel1_tag != '0);
   assign pop_mem   = (count != '0) & ~halt;

`ifdef RELEASE_BYPASS_EN
   logic bypass;
   assign bypass = (count == '0) & ~halt & (acc0 | acc1);
   // The first accepted tag goes straight out; only a second one is stored.
   assign wr0    = acc0 & ~bypass;
   assign wr1    = acc1 & ~(bypass & ~acc0);

   always_comb begin
      enque      = 1'b0;
      enque_data = '0;
      if (bypass) begin
         enque      = 1'b1;
         enque_data = acc0 ? rel0_tag : rel1_tag;
      end else if (pop_mem) begin
         enque      = 1'b1;
         enque_data = mem[head];
      end
   end
`else
   assign wr0        = acc0;
   assign wr1        = acc1;
   assign enque      = pop_mem;
   assign enque_data = pop_mem ? mem[head] : '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the entries are reset too, so no stale tag can ever be read back out.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every update based on this cycle's values.
         if (wr0) mem[tail] <= rel0_tag;
         if (wr1) mem[tail + AW'(wr0)] <= rel1_tag;
         tail  <= tail + AW'(wr0) + AW'(wr1);
         if (pop_mem) head <= head + AW'(1);
         count <= count + CW'(wr0) + CW'(wr1) - CW'(pop_mem);
      end
   end

endmodule

// File: tb/tb_reg_release.sv
// Scoreboard bench for reg_release: stimulus queues expected pushes, a negedge monitor checks them.
module tb_reg_release;

   localparam int DEPTH = 4;
   localparam int WIDTH = 6;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             reset;
   logic             rel0_valid, rel1_valid, halt, flush;
   logic [WIDTH-1:0] rel0_tag, rel1_tag;
   logic             rel_stall, enque;
   logic [WIDTH-1:0] enque_data;
   logic [CW-1:0]    pending;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] sb [$];

   always #5 clk = ~clk;

   reg_release #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .rel0_valid(rel0_valid), .rel0_tag(rel0_tag),
      .rel1_valid(rel1_valid), .rel1_tag(rel1_tag),
      .rel_stall(rel_stall), .enque(enque), .enque_data(enque_data),
      .halt(halt), .flush(flush), .pending(pending)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [WIDTH-1:0] t0,
                        input logic v1, input logic [WIDTH-1:0] t1);
      rel0_valid = v0; rel0_tag = t0;
      rel1_valid = v1; rel1_tag = t1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, '0);
   endtask

   // Monitor: every push must match the oldest expected tag; idle data must be zero.
   initial begin
      forever begin
         @(negedge clk);
         if (enque) begin
            if (sb.size() == 0) check("unexpected_push", {26'd0, enque_data}, 32'hFFFF_FFFF);
            else                check("push_data", {26'd0, enque_data}, {26'd0, sb.pop_front()});
         end else begin
            check("idle_data", {26'd0, enque_data}, 32'd0);
         end
      end
   end

   initial begin
      reset = 1'b0; halt = 1'b0; flush = 1'b0;
      idle();
      #12;
      check("rst_pending", pending, 0);
      check("rst_enque", enque, 0);
      check("rst_stall", rel_stall, 0);
      step();
      reset = 1'b1;
      step();

      // single release, one-cycle latency
      drive(1'b1, 6'h25, 1'b0, '0); sb.push_back(6'h25);
      step(); idle();
      check("single_pending", pending, 1);
      check("single_enque", enque, 1);
      step();
      check("single_drained", pending, 0);

      // two releases in one cycle, slot 0 first
      drive(1'b1, 6'h21, 1'b1, 6'h22); sb.push_back(6'h21); sb.push_back(6'h22);
      step(); idle();
      check("pair_pending", pending, 2);
      step(); step();
      check("pair_drained", pending, 0);

      // fill under halt, stall, ignore extra input, drain in order
      halt = 1'b1;
      drive(1'b1, 6'h30, 1'b1, 6'h31); sb.push_back(6'h30); sb.push_back(6'h31);
      step();
      check("fill2_pending", pending, 2);
      check("fill2_stall", rel_stall, 0);
      drive(1'b1, 6'h32, 1'b1, 6'h33); sb.push_back(6'h32); sb.push_back(6'h33);
      step();
      check("full_pending", pending, 4);
      check("full_stall", rel_stall, 1);
      check("full_no_push", enque, 0);
      drive(1'b1, 6'h3E, 1'b1, 6'h3F);
      step(); idle();
      check("ignored_pending", pending, 4);
      halt = 1'b0;
      #1;
      check("drain_first_data", enque_data, 6'h30);
      step();
      check("three_left_pending", pending, 3);
      check("three_left_stall", rel_stall, 1);
      step();
      check("two_left_stall", rel_stall, 0);
      step(); step();
      check("fill_drained", pending, 0);

      // tag zero discarded
      drive(1'b1, 6'h00, 1'b1, 6'h2A); sb.push_back(6'h2A);
      step(); idle();
      check("zero_tag_pending", pending, 1);
      step();
      check("zero_tag_drained", pending, 0);

      // flush leaves buffer untouched
      halt = 1'b1;
      drive(1'b1, 6'h11, 1'b1, 6'h12); sb.push_back(6'h11); sb.push_back(6'h12);
      step();
      drive(1'b1, 6'h13, 1'b0, '0); sb.push_back(6'h13);
      step(); idle();
      check("preflush_pending", pending, 3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("postflush_pending", pending, 3);
      check("postflush_stall", rel_stall, 1);
      halt = 1'b0;
      step(); step(); step();
      check("flush_drained", pending, 0);

      // mid-cycle reset discards buffered tags
      halt = 1'b1;
      drive(1'b1, 6'h05, 1'b1, 6'h06);
      step();
      drive(1'b1, 6'h07, 1'b0, '0);
      step(); idle();
      check("prereset_pending", pending, 3);
      #2 reset = 1'b0;
      #1;
      check("midreset_enque", enque, 0);
      check("midreset_pending", pending, 0);
      check("midreset_stall", rel_stall, 0);
      step();
      reset = 1'b1;
      halt  = 1'b0;
      step(); step(); step();
      check("postreset_pending", pending, 0);
      check("postreset_enque", enque, 0);

      step();
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_release.md
REG_RELEASE -- requirements
Module: reg_release

Interface
REQ-001 Parameter DEPTH, default 4, number of holding-buffer entries; power of two, at least 2.
REQ-002 Parameter WIDTH, default 6, physical register tag width.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port rel0_valid  input  1  commit slot 0 releases an old physical tag.
REQ-006 Port rel0_tag  input  WIDTH  tag released by slot 0.
REQ-007 Port rel1_valid  input  1  commit slot 1 releases an old physical tag.
REQ-008 Port rel1_tag  input  WIDTH  tag released by slot 1.
REQ-009 Port rel_stall  output  1  commit must hold; releases are not accepted this cycle.
REQ-010 Port enque  output  1  push enque_data into the free-list queue this cycle.
REQ-011 Port enque_data  output  WIDTH  tag being returned; 0 whenever enque=0.
REQ-012 Port halt  input  1  free-list queue full; no push may occur.
REQ-013 Port flush  input  1  pipeline flush indication.
REQ-014 Port pending  output  $clog2(DEPTH+1)  current holding-buffer occupancy.

Function
REQ-015 The block SHALL buffer freed tags in a circular FIFO of DEPTH entries, with head and tail pointers wrapping from DEPTH-1 to 0.
REQ-016 rel_stall SHALL be combinational and equal 1 exactly when pending > DEPTH-2.
REQ-017 While rel_stall=0, each valid slot carrying a nonzero tag SHALL be accepted, slot 0 ahead of slot 1; while rel_stall=1, both slots SHALL be ignored.
REQ-018 Tag 0, the hardwired-zero register, SHALL be discarded silently, with no buffer write and no push.
REQ-019 enque SHALL equal (pending>0) & ~halt; enque_data SHALL equal the head entry when enque=1.
REQ-020 On each enque=1 cycle the head SHALL advance by one; when halt=1 the head entry and the head pointer SHALL hold.
REQ-021 Next occupancy SHALL be pending + accepted (0..2) - popped (0..1), all in the same cycle; it SHALL never exceed DEPTH or underflow.
REQ-022 Latency SHALL be one cycle: a tag accepted in cycle N SHALL appear on enque no earlier than cycle N+1, in acceptance order.
REQ-023 flush SHALL NOT alter buffer contents, pointers or outputs, because committed releases are architectural.
REQ-024 When pending=DEPTH-1 and halt=0, rel_stall SHALL be 1, and the pop SHALL lower pending to DEPTH-2 for the next cycle.

Reset
REQ-025 On reset=0 the block SHALL clear all entries, head, tail and pending to 0, drive enque=0, enque_data=0 and rel_stall=0, and hold this state until reset=1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered tags immediately, with no push in that cycle.

Configuration
REQ-027 Macro RELEASE_BYPASS_EN: when defined, if pending=0, halt=0 and at least one nonzero tag is accepted, the first accepted tag SHALL drive enque/enque_data in the same cycle without being stored, and any second tag SHALL be stored.
REQ-028 Without RELEASE_BYPASS_EN, every accepted tag SHALL be stored first, and enque SHALL depend only on registered state and halt.

Verification
REQ-029 Reset, then rel0_valid=1, rel0_tag=0x25, halt=0 in cycle 1 -> enque=1, enque_data=0x25 in cycle 2 (cycle 1 when bypass is enabled), pending=0 afterwards.
REQ-030 rel0=0x21 and rel1=0x22 in the same cycle, halt=0 -> pushes 0x21 then 0x22 on consecutive cycles.
REQ-031 halt=1, with pairs 0x30/0x31 then 0x32/0x33 -> pending=4 and rel_stall=1; further inputs are ignored; after halt=0, pushes 0x30, 0x31, 0x32, 0x33 in order.
REQ-032 rel0_tag=0 and rel1_tag=0x2A, both valid -> only 0x2A is pushed and pending peaks at 1.
REQ-033 Three tags buffered with halt=1, then flush=1 for one cycle -> pending stays 3 and the same three tags drain afterwards.
REQ-034 Three tags buffered, then reset=0 pulsed mid-cycle -> enque=0 and pending=0 immediately, and no stale tag is ever pushed.
